uart_byte_rx: RTL

//   Serial receiver feeding the MIX input (card-reader) unit: recovers 8N1 bytes from
//   the asynchronous rx pin, presents each byte on out[7:0] with a one-cycle stop strobe.

---
 rtl/uart_byte_rx.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 serial byte receiver with glitch rejection and framing-error strobe
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset      in   synchronous, active-high
//   rx         in   asynchronous serial line, idle high, LSB first, 8N1
//   out[7:0]   out  last good byte, held until the next good byte
//   stop       out  one-cycle strobe: out carries a new byte this cycle
//   frame_err  out  one-cycle strobe: stop bit sampled low, byte discarded
//   busy       out  high whenever a frame is in progress (state != IDLE)

module uart_byte_rx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic [7:0] out,
    output logic       stop,
    output logic       frame_err,
    output logic       busy
);

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Metastability chain; flops reset to the idle (high) line level so a
    // reset never looks like a start bit.
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_q[SYNC_STAGES-1];

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sh_q, sh_d;
    logic [7:0]  out_q, out_d;
    logic        stop_q, stop_d;
    logic        ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
            out_q   <= '0;
            stop_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
            out_q   <= out_d;
            stop_q  <= stop_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        out_d   = out_q;
        stop_d  = 1'b0;
        ferr_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = S_START;
                end
            end

            // Re-check the line at the middle of the start bit; a pulse that
            // is already gone by then is a glitch, not a frame.
            S_START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = '0;
                    idx_d = '0;
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            // Counting restarts at the start-bit centre, so each full bit
            // period lands on the next data-bit centre.
            S_DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    sh_d  = {rx_s, sh_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            // Returning to IDLE at the stop-bit centre leaves half a bit of
            // slack to catch an immediately following start bit.
            S_STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        out_d   = sh_q;
                        stop_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            // A line held low after a bad frame must not look like a new start.
            S_BREAK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign out       = out_q;
    assign stop      = stop_q;
    assign frame_err = ferr_q;
    assign busy      = (state_q != S_IDLE);

endmodule
